// File: rtl/trace_capture_ctrl_if.sv
// Bundles the trace capture sequencer's control, status and FIFO-gating
// signals. The master side drives requests and configuration; the slave
// side is the sequencer itself.
interface trace_capture_ctrl_if #(
  parameter int unsigned pDELAY_WIDTH = 16,
  parameter int unsigned pLEN_WIDTH   = 18
);
  logic                    I_arm;
  logic                    I_abort;
  logic                    I_trig_sel;
  logic                    I_match;
  logic                    I_m3_trig;
  logic [pDELAY_WIDTH-1:0] I_trig_delay;
  logic [pLEN_WIDTH-1:0]   I_capture_len;
  logic [7:0]              I_trig_width;
  logic                    I_data_valid;
  logic                    I_fifo_full;
  logic                    O_fifo_wr;
  logic                    O_trig_out;
  logic                    O_arm;
  logic                    O_capturing;
  logic                    O_done;
  logic                    O_overflow;
  logic [pLEN_WIDTH-1:0]   O_word_count;
  logic [2:0]              O_state;

  modport master (
    output I_arm, I_abort, I_trig_sel, I_match, I_m3_trig, I_trig_delay,
           I_capture_len, I_trig_width, I_data_valid, I_fifo_full,
    input  O_fifo_wr, O_trig_out, O_arm, O_capturing, O_done, O_overflow,
           O_word_count, O_state
  );

  modport slave (
    input  I_arm, I_abort, I_trig_sel, I_match, I_m3_trig, I_trig_delay,
           I_capture_len, I_trig_width, I_data_valid, I_fifo_full,
    output O_fifo_wr, O_trig_out, O_arm, O_capturing, O_done, O_overflow,
           O_word_count, O_state
  );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Capture sequencer for the trace sniffer: arm, wait for a pattern match or
// M3 GPIO rising edge, delay, then gate trace words into the capture FIFO
// while driving the external trigger pulse and status flags.
module trace_capture_ctrl #(
  parameter int unsigned pDELAY_WIDTH = 16,
  parameter int unsigned pLEN_WIDTH   = 18
) (
  input logic                  target_clk,
  input logic                  reset,
  trace_capture_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                  state, state_nx;
  logic                    m3_prev;
  logic                    trig_evt;
  logic                    trig_acc;
  logic                    wr_en;
  logic                    ovf_evt;
  logic                    last_word;
  logic                    arm_clear;
  logic [pDELAY_WIDTH-1:0] delay_cnt, delay_cnt_nx;
  logic [7:0]              pulse_cnt;
  logic [pLEN_WIDTH-1:0]   word_count;
  logic                    overflow;
  logic                    arm_q;
  logic                    capturing_q;
  logic                    done_q;

  // Select the trigger source: pattern hit or GPIO rising edge.
  always_comb begin
    trig_evt = bus.I_trig_sel ? (bus.I_m3_trig & ~m3_prev) : bus.I_match;
  end

  // Next-state and FIFO gating decode.
  always_comb begin
    state_nx     = state;
    delay_cnt_nx = delay_cnt;
    trig_acc     = 1'b0;
    wr_en        = 1'b0;
    ovf_evt      = 1'b0;
    last_word    = 1'b0;
    arm_clear    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.I_arm) begin
          state_nx  = ST_ARMED;
          arm_clear = 1'b1;
        end
      end
      ST_ARMED: begin
        if (trig_evt) begin
          trig_acc = 1'b1;
          // Counter holds delay-1 so capture begins exactly I_trig_delay
          // cycles after the event; delays of 0 and 1 skip DELAY entirely.
          if (bus.I_trig_delay <= pDELAY_WIDTH'(1)) begin
            state_nx = ST_CAPTURE;
          end else begin
            state_nx     = ST_DELAY;
            delay_cnt_nx = bus.I_trig_delay - pDELAY_WIDTH'(1);
          end
        end
      end
      ST_DELAY: begin
        if (delay_cnt == pDELAY_WIDTH'(1)) begin
          state_nx = ST_CAPTURE;
        end else begin
          delay_cnt_nx = delay_cnt - pDELAY_WIDTH'(1);
        end
      end
      ST_CAPTURE: begin
        wr_en     = bus.I_data_valid & ~bus.I_fifo_full;
        ovf_evt   = bus.I_data_valid & bus.I_fifo_full;
        last_word = wr_en && (bus.I_capture_len != '0) &&
                    (word_count == bus.I_capture_len - pLEN_WIDTH'(1));
        if (ovf_evt || last_word) begin
          state_nx = ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Abort wins over everything; writes are suppressed so the word count
    // stays consistent with what actually reached the FIFO.
    if (bus.I_abort) begin
      state_nx  = ST_IDLE;
      trig_acc  = 1'b0;
      wr_en     = 1'b0;
      ovf_evt   = 1'b0;
      last_word = 1'b0;
      arm_clear = 1'b0;
    end
  end

  // State, counters and registered status flags.
  always_ff @(posedge target_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      delay_cnt   <= '0;
      m3_prev     <= 1'b0;
      pulse_cnt   <= '0;
      word_count  <= '0;
      overflow    <= 1'b0;
      arm_q       <= 1'b0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state     <= state_nx;
      delay_cnt <= delay_cnt_nx;
      m3_prev   <= bus.I_m3_trig;

      if (bus.I_abort) begin
        pulse_cnt <= '0;
      end else if (trig_acc) begin
        pulse_cnt <= bus.I_trig_width;
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 8'd1;
      end

      if (arm_clear) begin
        word_count <= '0;
      end else if (wr_en && (word_count != '1)) begin
        word_count <= word_count + pLEN_WIDTH'(1);
      end

      if (arm_clear) begin
        overflow <= 1'b0;
      end else if (ovf_evt) begin
        overflow <= 1'b1;
      end

      arm_q       <= (state_nx == ST_ARMED);
      capturing_q <= (state_nx == ST_DELAY) || (state_nx == ST_CAPTURE);
      done_q      <= (state_nx == ST_DONE);
    end
  end

  assign bus.O_fifo_wr    = wr_en;
  assign bus.O_trig_out   = (pulse_cnt != '0);
  assign bus.O_arm        = arm_q;
  assign bus.O_capturing  = capturing_q;
  assign bus.O_done       = done_q;
  assign bus.O_overflow   = overflow;
  assign bus.O_word_count = word_count;
  assign bus.O_state      = state;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl with an expected-value scoreboard.
module tb_trace_capture_ctrl;

  logic target_clk = 1'b0;
  logic reset;

  trace_capture_ctrl_if #(.pDELAY_WIDTH(16), .pLEN_WIDTH(18)) bus ();

  trace_capture_ctrl #(.pDELAY_WIDTH(16), .pLEN_WIDTH(18)) dut (
    .target_clk (target_clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 target_clk = ~target_clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   wr_n;
  int   trig_n;

  task automatic tick();
    @(posedge target_clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h required=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Counts writes and trigger-high cycles over n cycles at posedge+1.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (bus.O_fifo_wr)  wr_n++;
      if (bus.O_trig_out) trig_n++;
      tick();
    end
  endtask

  task automatic do_arm();
    bus.I_arm = 1'b1;
    tick();
    bus.I_arm = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.I_arm         = 1'b0;
    bus.I_abort       = 1'b0;
    bus.I_trig_sel    = 1'b0;
    bus.I_match       = 1'b0;
    bus.I_m3_trig     = 1'b0;
    bus.I_trig_delay  = '0;
    bus.I_capture_len = '0;
    bus.I_trig_width  = '0;
    bus.I_data_valid  = 1'b0;
    bus.I_fifo_full   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    expect_val("rst_state", 0);     check(32'(bus.O_state));
    expect_val("rst_outs", 0);
    check({26'd0, bus.O_fifo_wr, bus.O_trig_out, bus.O_arm, bus.O_capturing,
           bus.O_done, bus.O_overflow});
    expect_val("rst_count", 0);     check(32'(bus.O_word_count));

    // Match trigger, no delay, 4 words, 3-cycle pulse
    bus.I_trig_sel    = 1'b0;
    bus.I_trig_delay  = 16'd0;
    bus.I_capture_len = 18'd4;
    bus.I_trig_width  = 8'd3;
    bus.I_data_valid  = 1'b1;
    do_arm();
    expect_val("s1_arm", 1);        check(32'(bus.O_arm));
    expect_val("s1_state_armed", 1); check(32'(bus.O_state));
    bus.I_match = 1'b1;
    tick();
    bus.I_match = 1'b0;
    expect_val("s1_capturing", 1);  check(32'(bus.O_capturing));
    expect_val("s1_state_cap", 3);  check(32'(bus.O_state));
    expect_val("s1_writes", 4);
    expect_val("s1_trig_cycles", 3);
    wr_n = 0; trig_n = 0;
    run(8);
    check(32'(wr_n));
    check(32'(trig_n));
    expect_val("s1_done", 1);       check(32'(bus.O_done));
    expect_val("s1_count", 4);      check(32'(bus.O_word_count));
    expect_val("s1_state_done", 4); check(32'(bus.O_state));

    // M3 rising edge, delay 5, length 2
    bus.I_trig_sel    = 1'b1;
    bus.I_trig_delay  = 16'd5;
    bus.I_capture_len = 18'd2;
    do_arm();
    expect_val("s2_count_clr", 0);  check(32'(bus.O_word_count));
    bus.I_m3_trig = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) begin
      expect_val($sformatf("s2_state_T%0d", k), (k < 5) ? 2 : ((k < 7) ? 3 : 4));
      check(32'(bus.O_state));
      if (k == 4 || k == 5) begin
        expect_val($sformatf("s2_wr_T%0d", k), (k == 5) ? 1 : 0);
        check(32'(bus.O_fifo_wr));
      end
      if (k == 2) bus.I_m3_trig = 1'b0;
      tick();
    end
    expect_val("s2_count", 2);      check(32'(bus.O_word_count));

    // Overflow in unlimited mode after 2 writes
    bus.I_trig_sel    = 1'b0;
    bus.I_trig_delay  = 16'd0;
    bus.I_capture_len = 18'd0;
    do_arm();
    bus.I_match = 1'b1;
    tick();
    bus.I_match = 1'b0;
    expect_val("s3_writes", 2);
    wr_n = 0; trig_n = 0;
    run(2);
    check(32'(wr_n));
    bus.I_fifo_full = 1'b1;
    #1;
    expect_val("s3_no_wr_full", 0); check(32'(bus.O_fifo_wr));
    tick();
    bus.I_fifo_full = 1'b0;
    expect_val("s3_overflow", 1);   check(32'(bus.O_overflow));
    expect_val("s3_count", 2);      check(32'(bus.O_word_count));
    expect_val("s3_done", 1);       check(32'(bus.O_done));

    // Rearm from DONE clears overflow; abort in DELAY kills a long pulse
    bus.I_trig_delay  = 16'd10;
    bus.I_capture_len = 18'd4;
    bus.I_trig_width  = 8'd200;
    do_arm();
    expect_val("s4_ovf_clr", 0);    check(32'(bus.O_overflow));
    expect_val("s4_done_clr", 0);   check(32'(bus.O_done));
    bus.I_match = 1'b1;
    tick();
    bus.I_match = 1'b0;
    expect_val("s4_trig_hi", 1);    check(32'(bus.O_trig_out));
    tick();
    tick();
    expect_val("s4_state_delay", 2); check(32'(bus.O_state));
    bus.I_abort = 1'b1;
    tick();
    bus.I_abort = 1'b0;
    expect_val("s4_state_idle", 0); check(32'(bus.O_state));
    expect_val("s4_trig_lo", 0);    check(32'(bus.O_trig_out));
    expect_val("s4_writes", 0);
    expect_val("s4_trig_cycles", 0);
    wr_n = 0; trig_n = 0;
    run(15);
    check(32'(wr_n));
    check(32'(trig_n));

    // Trigger coincident with abort is discarded
    do_arm();
    bus.I_match = 1'b1;
    bus.I_abort = 1'b1;
    tick();
    bus.I_match = 1'b0;
    bus.I_abort = 1'b0;
    expect_val("s5_abort_trig_state", 0); check(32'(bus.O_state));
    expect_val("s5_abort_trig_pulse", 0); check(32'(bus.O_trig_out));

    // Retrigger and rearm attempts during CAPTURE are ignored
    bus.I_trig_delay  = 16'd0;
    bus.I_capture_len = 18'd6;
    bus.I_trig_width  = 8'd2;
    do_arm();
    bus.I_match = 1'b1;
    tick();
    wr_n = 0; trig_n = 0;
    for (int i = 0; i < 10; i++) begin
      bus.I_match      = (i == 1 || i == 3);
      bus.I_arm        = (i == 2);
      bus.I_data_valid = (i != 4);
      #1;
      if (bus.O_fifo_wr)  wr_n++;
      if (bus.O_trig_out) trig_n++;
      tick();
    end
    bus.I_match      = 1'b0;
    bus.I_arm        = 1'b0;
    bus.I_data_valid = 1'b1;
    expect_val("s6_writes", 6);     check(32'(wr_n));
    expect_val("s6_trig_cycles", 2); check(32'(trig_n));
    expect_val("s6_count", 6);      check(32'(bus.O_word_count));
    expect_val("s6_state_done", 4); check(32'(bus.O_state));

    // Reset together with abort in the middle of an unlimited capture
    bus.I_capture_len = 18'd0;
    bus.I_trig_width  = 8'd3;
    do_arm();
    bus.I_match = 1'b1;
    tick();
    bus.I_match = 1'b0;
    tick();
    tick();
    expect_val("s7_pre_state", 3);  check(32'(bus.O_state));
    reset       = 1'b1;
    bus.I_abort = 1'b1;
    tick();
    reset       = 1'b0;
    bus.I_abort = 1'b0;
    expect_val("s7_state", 0);      check(32'(bus.O_state));
    expect_val("s7_outs", 0);
    check({26'd0, bus.O_fifo_wr, bus.O_trig_out, bus.O_arm, bus.O_capturing,
           bus.O_done, bus.O_overflow});
    expect_val("s7_count", 0);      check(32'(bus.O_word_count));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
